// File: rtl/elevator_req_scheduler.sv
// SCAN-policy request scheduler and motion sequencer for a NUM_FLOORS elevator car.
// Requests land in o_pending one edge after sampling; motion follows one edge later; no backpressure, drive paces travel via i_floor_step.
module elevator_req_scheduler #(
    parameter int NUM_FLOORS  = 5,
    parameter int DOOR_CYCLES = 8,
    parameter int FLOOR_W     = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_FLOORS-1:0] i_req_ext,
    input  logic [NUM_FLOORS-1:0] i_req_inter,
    input  logic                  i_stop,
    input  logic                  i_floor_step,
    output logic [FLOOR_W-1:0]    o_current_floor,
    output logic [FLOOR_W-1:0]    o_target_floor,
    output logic                  o_up,
    output logic                  o_down,
    output logic                  o_door,
    output logic [NUM_FLOORS-1:0] o_pending
);

    localparam int TW = $clog2(DOOR_CYCLES) + 1;
    localparam logic [FLOOR_W-1:0] TOP   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [TW-1:0]      DWELL = TW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR, HALT} state_t;

    state_t                  state, state_nxt;
    logic [FLOOR_W-1:0]      cur, cur_nxt;
    logic [NUM_FLOORS-1:0]   pending, pending_nxt;
    logic [TW-1:0]           timer, timer_nxt;
    logic                    last_dir, last_dir_nxt;

    logic [NUM_FLOORS-1:0]   req, cur_oh;
    logic [FLOOR_W-1:0]      nxt_floor;
    logic                    above, below;
    logic [FLOOR_W-1:0]      up_tgt, dn_tgt;

    // Nearest pending floor each way; loop order makes the last hit the closest one.
    always_comb begin
        above  = 1'b0;
        below  = 1'b0;
        up_tgt = '0;
        dn_tgt = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > cur)) begin
                above  = 1'b1;
                up_tgt = FLOOR_W'(i + 1);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < cur)) begin
                below  = 1'b1;
                dn_tgt = FLOOR_W'(i + 1);
            end
        end
    end

    always_comb begin
        req          = i_req_ext | i_req_inter;
        cur_oh       = NUM_FLOORS'(1) << cur;
        state_nxt    = state;
        cur_nxt      = cur;
        pending_nxt  = pending | req;
        timer_nxt    = timer;
        last_dir_nxt = last_dir;
        nxt_floor    = cur;

        if (i_stop) begin
            state_nxt = HALT;
        end else begin
            case (state)
                IDLE: begin
                    // A call for the floor the car is parked at just opens the door.
                    pending_nxt = (pending | req) & ~cur_oh;
                    if (((pending | req) & cur_oh) != '0) begin
                        state_nxt = DOOR;
                        timer_nxt = DWELL;
                    end else if (above) begin
                        state_nxt = MOVE_UP;
                    end else if (below) begin
                        state_nxt = MOVE_DOWN;
                    end
                end
                MOVE_UP: begin
                    if (i_floor_step && (cur != TOP)) begin
                        nxt_floor = cur + FLOOR_W'(1);
                        cur_nxt   = nxt_floor;
                        if (pending[nxt_floor]) begin
                            state_nxt    = DOOR;
                            pending_nxt  = (pending | req) & ~(NUM_FLOORS'(1) << nxt_floor);
                            timer_nxt    = DWELL;
                            last_dir_nxt = 1'b1;
                        end
                    end
                end
                MOVE_DOWN: begin
                    if (i_floor_step && (cur != '0)) begin
                        nxt_floor = cur - FLOOR_W'(1);
                        cur_nxt   = nxt_floor;
                        if (pending[nxt_floor]) begin
                            state_nxt    = DOOR;
                            pending_nxt  = (pending | req) & ~(NUM_FLOORS'(1) << nxt_floor);
                            timer_nxt    = DWELL;
                            last_dir_nxt = 1'b0;
                        end
                    end
                end
                DOOR: begin
                    pending_nxt = (pending | req) & ~cur_oh;
                    if (((pending | req) & cur_oh) != '0) begin
                        timer_nxt = DWELL;
                    end else if (timer == '0) begin
                        if (last_dir && above) begin
                            state_nxt = MOVE_UP;
                        end else if (below) begin
                            state_nxt = MOVE_DOWN;
                        end else if (above) begin
                            state_nxt = MOVE_UP;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                HALT:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cur      <= '0;
            pending  <= '0;
            timer    <= '0;
            last_dir <= 1'b1;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            pending  <= pending_nxt;
            timer    <= timer_nxt;
            last_dir <= last_dir_nxt;
        end
    end

    assign o_up            = (state == MOVE_UP);
    assign o_down          = (state == MOVE_DOWN);
    assign o_door          = (state == DOOR) || (state == IDLE);
    assign o_pending       = pending;
    assign o_current_floor = cur + FLOOR_W'(1);
    assign o_target_floor  = (state == MOVE_UP)   ? up_tgt :
                             (state == MOVE_DOWN) ? dn_tgt : '0;

endmodule

// File: tb/tb_elevator_req_scheduler.sv
// Scoreboard bench for elevator_req_scheduler: each driven cycle queues its expected outputs, popped after the edge.
module tb_elevator_req_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] req_ext = '0;
    logic [4:0] req_inter = '0;
    logic       stop = 1'b0;
    logic       floor_step = 1'b0;
    logic [2:0] current_floor, target_floor;
    logic       up, down, door;
    logic [4:0] pending;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [2:0] cur;
        logic [2:0] tgt;
        logic       up;
        logic       dn;
        logic       door;
        logic [4:0] pend;
    } exp_t;

    exp_t sb[$];

    elevator_req_scheduler #(.NUM_FLOORS(5), .DOOR_CYCLES(8), .FLOOR_W(3)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .i_req_ext       (req_ext),
        .i_req_inter     (req_inter),
        .i_stop          (stop),
        .i_floor_step    (floor_step),
        .o_current_floor (current_floor),
        .o_target_floor  (target_floor),
        .o_up            (up),
        .o_down          (down),
        .o_door          (door),
        .o_pending       (pending)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cur"},  32'(current_floor), 32'd1);
        check({tag, "_tgt"},  32'(target_floor),  32'd0);
        check({tag, "_up"},   32'(up),            32'd0);
        check({tag, "_dn"},   32'(down),          32'd0);
        check({tag, "_door"}, 32'(door),          32'd1);
        check({tag, "_pend"}, 32'(pending),       32'd0);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_cur"},  32'(current_floor), 32'(e.cur));
        check({e.tag, "_tgt"},  32'(target_floor),  32'(e.tgt));
        check({e.tag, "_up"},   32'(up),            32'(e.up));
        check({e.tag, "_dn"},   32'(down),          32'(e.dn));
        check({e.tag, "_door"}, 32'(door),          32'(e.door));
        check({e.tag, "_pend"}, 32'(pending),       32'(e.pend));
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next edge, then compare.
    task automatic step(input string tag, input logic [4:0] ext, input logic [4:0] inter,
                        input logic stp, input logic fstep,
                        input logic [2:0] ecur, input logic [2:0] etgt,
                        input logic eup, input logic edn, input logic edoor, input logic [4:0] epend);
        exp_t e;
        @(negedge CLK);
        req_ext    = ext;
        req_inter  = inter;
        stop       = stp;
        floor_step = fstep;
        e.tag = tag; e.cur = ecur; e.tgt = etgt; e.up = eup; e.dn = edn; e.door = edoor; e.pend = epend;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        compare_out();
    endtask

    task automatic nop(input string tag, input logic [2:0] ecur, input logic [2:0] etgt,
                       input logic eup, input logic edn, input logic edoor, input logic [4:0] epend);
        step(tag, 5'b0, 5'b0, 1'b0, 1'b0, ecur, etgt, eup, edn, edoor, epend);
    endtask

    task automatic fstep(input string tag, input logic [2:0] ecur, input logic [2:0] etgt,
                         input logic eup, input logic edn, input logic edoor, input logic [4:0] epend);
        step(tag, 5'b0, 5'b0, 1'b0, 1'b1, ecur, etgt, eup, edn, edoor, epend);
    endtask

    task automatic dwell(input int n, input string tag, input logic [2:0] ecur, input logic [4:0] epend);
        for (int i = 0; i < n; i++)
            nop($sformatf("%s%0d", tag, i), ecur, 3'd0, 1'b0, 1'b0, 1'b1, epend);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check_reset_outputs("rst");
        @(negedge CLK);
        RST = 1'b0;

        // Call for the parked floor is served in place and never latched.
        step("s0_inplace", 5'b0, 5'b00001, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
        dwell(8, "s0_door", 3'd1, 5'b00000);

        // Ground to fourth floor.
        step("s1_req", 5'b0, 5'b01000, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b01000);
        nop("s1_go",     3'd1, 3'd4, 1'b1, 1'b0, 1'b0, 5'b01000);
        fstep("s1_f2",   3'd2, 3'd4, 1'b1, 1'b0, 1'b0, 5'b01000);
        fstep("s1_f3",   3'd3, 3'd4, 1'b1, 1'b0, 1'b0, 5'b01000);
        fstep("s1_land", 3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
        dwell(8, "s1_door", 3'd4, 5'b00000);

        // Back to ground, then two hall calls served upward with a stop in between.
        step("s2_home", 5'b0, 5'b00001, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00001);
        nop("s2_hgo",    3'd4, 3'd1, 1'b0, 1'b1, 1'b0, 5'b00001);
        fstep("s2_h3",   3'd3, 3'd1, 1'b0, 1'b1, 1'b0, 5'b00001);
        fstep("s2_h2",   3'd2, 3'd1, 1'b0, 1'b1, 1'b0, 5'b00001);
        fstep("s2_hland",3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
        dwell(8, "s2_hdoor", 3'd1, 5'b00000);
        step("s2_req", 5'b10100, 5'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b10100);
        nop("s2_go",     3'd1, 3'd3, 1'b1, 1'b0, 1'b0, 5'b10100);
        fstep("s2_f2",   3'd2, 3'd3, 1'b1, 1'b0, 1'b0, 5'b10100);
        fstep("s2_land3",3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 5'b10000);
        dwell(7, "s2_door3_", 3'd3, 5'b10000);
        nop("s2_cont",   3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 5'b10000);
        fstep("s2_f4",   3'd4, 3'd5, 1'b1, 1'b0, 1'b0, 5'b10000);
        fstep("s2_land5",3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
        dwell(8, "s2_door5_", 3'd5, 5'b00000);

        // Down to floor 2, then up with a ground call added mid-travel: top first, then reverse.
        step("s3_req2", 5'b0, 5'b00010, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00010);
        nop("s3_go2",    3'd5, 3'd2, 1'b0, 1'b1, 1'b0, 5'b00010);
        fstep("s3_f4",   3'd4, 3'd2, 1'b0, 1'b1, 1'b0, 5'b00010);
        fstep("s3_f3",   3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 5'b00010);
        fstep("s3_land2",3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
        dwell(8, "s3_door2_", 3'd2, 5'b00000);
        step("s3_req5", 5'b10000, 5'b0, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 5'b10000);
        nop("s3_go5",    3'd2, 3'd5, 1'b1, 1'b0, 1'b0, 5'b10000);
        step("s3_reqstep", 5'b0, 5'b00001, 1'b0, 1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 5'b10001);
        fstep("s3_f4u",  3'd4, 3'd5, 1'b1, 1'b0, 1'b0, 5'b10001);
        fstep("s3_land5",3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00001);
        dwell(7, "s3_door5_", 3'd5, 5'b00001);
        nop("s3_rev",    3'd5, 3'd1, 1'b0, 1'b1, 1'b0, 5'b00001);
        fstep("s3_d4",   3'd4, 3'd1, 1'b0, 1'b1, 1'b0, 5'b00001);
        fstep("s3_d3",   3'd3, 3'd1, 1'b0, 1'b1, 1'b0, 5'b00001);
        fstep("s3_d2",   3'd2, 3'd1, 1'b0, 1'b1, 1'b0, 5'b00001);
        fstep("s3_land1",3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);

        // Dwell reload: without it the car would leave for floor 3 six cycles earlier.
        step("s4_req3", 5'b00100, 5'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00100);
        dwell(4, "s4_pre", 3'd1, 5'b00100);
        step("s4_reload", 5'b0, 5'b00001, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00100);
        dwell(7, "s4_hold", 3'd1, 5'b00100);
        nop("s4_go",     3'd1, 3'd3, 1'b1, 1'b0, 1'b0, 5'b00100);

        // Emergency stop mid-travel.
        fstep("s5_f2",   3'd2, 3'd3, 1'b1, 1'b0, 1'b0, 5'b00100);
        step("s5_stop",  5'b0, 5'b0, 1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00100);
        step("s5_stepign", 5'b0, 5'b0, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00100);
        step("s5_latch", 5'b10000, 5'b0, 1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'b10100);
        nop("s5_release",3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 5'b10100);
        nop("s5_resume", 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, 5'b10100);
        fstep("s5_land3",3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 5'b10000);
        dwell(7, "s5_door3_", 3'd3, 5'b10000);
        nop("s5_cont",   3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 5'b10000);
        fstep("s5_f4",   3'd4, 3'd5, 1'b1, 1'b0, 1'b0, 5'b10000);
        fstep("s5_land5",3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);

        // Top floor: step pulse ignored; then async reset during the dwell.
        fstep("s6_topstep", 3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
        step("s6_req1", 5'b0, 5'b00001, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00001);
        @(negedge CLK);
        req_inter = '0;
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("s6_arst");
        @(posedge CLK);
        #1;
        check_reset_outputs("s6_arst_hold");
        @(negedge CLK);
        RST = 1'b0;
        nop("s6_after", 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
